// File: rtl/fpga_debug_capture.sv
// fpga_debug_capture
// Debug capture and display block for the RFID tag FPGA harness. Latches up to
// NCH tag-internal values on their completion strobes and shows the selected
// channel on NDIG seven-segment digits. It can also dump that channel serially
// on two GPIO pins.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   strobe[k]    capture event for channel k; asynchronous, held >= 3 clk
//   data         channel k value at [k*WIDTH +: WIDTH], stable while strobe[k] high
//   sel          channel shown on hex, ser_*, evt_cnt
//   freeze       high = ignore all captures (flagged in overrun)
//   shift_start  single-cycle pulse that starts a serial dump of cap[sel]
//   hex          digit d at [d*7 +: 7], active-low segments, bit0=a .. bit6=g
//   ser_clk      serial dump clock (receiver samples on its rising edge)
//   ser_data     serial dump data, MSB first
//   ser_busy     high while a dump is in progress
//   evt_cnt      saturating accepted-capture count of the selected channel
//   overrun      sticky per channel: strobe edge arrived while frozen
//
// Handshake: shift_start is a request that is accepted only in a cycle where
// ser_busy is low. While ser_busy is high, further requests are dropped. ser_busy
// falls in the cycle after the last ser_clk high phase ends.
module fpga_debug_capture #(
   parameter int NCH    = 4,
   parameter int SELW   = 2,
   parameter int WIDTH  = 16,
   parameter int NDIG   = 4,
   parameter int CLKDIV = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NCH-1:0]       strobe,
   input  logic [NCH*WIDTH-1:0] data,
   input  logic [SELW-1:0]      sel,
   input  logic                 freeze,
   input  logic                 shift_start,
   output logic [7*NDIG-1:0]    hex,
   output logic                 ser_clk,
   output logic                 ser_data,
   output logic                 ser_busy,
   output logic [7:0]           evt_cnt,
   output logic [NCH-1:0]       overrun
);

   localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int DIVW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   // The value is zero-extended so every digit's nibble select stays in range.
   localparam int PADW = WIDTH + 4*NDIG;
   localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLKDIV - 1);

   // ---------------------------------------------------------------- capture
   logic [NCH-1:0] sync1, sync2, sync3;
   logic [NCH-1:0] strobe_rise;
   logic [WIDTH-1:0] cap [NCH];
   logic [7:0]       evt [NCH];

   // sync1/sync2 form the synchroniser. sync3 holds the previous synchronised
   // level, so each strobe gives one rise no matter how long it is held.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         sync3 <= '0;
      end else begin
         sync1 <= strobe;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign strobe_rise = sync2 & ~sync3;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NCH; k++) begin
            cap[k] <= '0;
            evt[k] <= '0;
         end
         overrun <= '0;
      end else begin
         for (int k = 0; k < NCH; k++) begin
            if (strobe_rise[k]) begin
               if (freeze) begin
                  overrun[k] <= 1'b1;
               end else begin
                  cap[k] <= data[k*WIDTH +: WIDTH];
                  if (evt[k] != 8'hFF) evt[k] <= evt[k] + 8'd1;
               end
            end
         end
      end
   end

   // ------------------------------------------------------ selected channel
   // An out-of-range sel matches no channel. It then reads as value 0 with
   // count 0, and all digits are blanked.
   logic             sel_ok;
   logic [WIDTH-1:0] sel_cap;
   logic [7:0]       sel_evt;

   always_comb begin
      sel_ok  = 1'b0;
      sel_cap = '0;
      sel_evt = '0;
      for (int k = 0; k < NCH; k++) begin
         if (32'(sel) == 32'(k)) begin
            sel_ok  = 1'b1;
            sel_cap = cap[k];
            sel_evt = evt[k];
         end
      end
   end

   assign evt_cnt = sel_evt;

   // ---------------------------------------------------------------- display
   function automatic logic [6:0] seg7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   function automatic logic [7*NDIG-1:0] hex_of(input logic [WIDTH-1:0] v, input logic ok);
      logic [PADW-1:0]   p;
      logic [7*NDIG-1:0] r;
      p = PADW'(v);
      r = '0;
      for (int d = 0; d < NDIG; d++) begin
         if (!ok || (d*4 >= WIDTH)) r[d*7 +: 7] = 7'h7F;
         else                       r[d*7 +: 7] = seg7(p[d*4 +: 4]);
      end
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) hex <= hex_of('0, sel_ok);
      else       hex <= hex_of(sel_cap, sel_ok);
   end

   // ------------------------------------------------------------ serial dump
   typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} ser_state_t;

   ser_state_t       state, state_nx;
   logic [WIDTH-1:0] shreg, shreg_nx;
   logic [CNTW-1:0]  bit_cnt, bit_cnt_nx;
   logic [DIVW-1:0]  div_cnt, div_cnt_nx;
   logic             data_nx, busy_nx;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         shreg    <= '0;
         bit_cnt  <= '0;
         div_cnt  <= '0;
         ser_data <= 1'b0;
         ser_busy <= 1'b0;
         ser_clk  <= 1'b0;
      end else begin
         state    <= state_nx;
         shreg    <= shreg_nx;
         bit_cnt  <= bit_cnt_nx;
         div_cnt  <= div_cnt_nx;
         ser_data <= data_nx;
         ser_busy <= busy_nx;
         ser_clk  <= (state_nx == S_HIGH);
      end
   end

   always_comb begin
      state_nx   = state;
      shreg_nx   = shreg;
      bit_cnt_nx = bit_cnt;
      div_cnt_nx = div_cnt;
      data_nx    = ser_data;
      busy_nx    = ser_busy;
      case (state)
         S_IDLE: begin
            if (shift_start) begin
               // The dump works on this snapshot, so later captures leave it unchanged.
               shreg_nx   = sel_cap;
               bit_cnt_nx = CNTW'(WIDTH - 1);
               div_cnt_nx = '0;
               data_nx    = sel_cap[WIDTH-1];
               busy_nx    = 1'b1;
               state_nx   = S_LOW;
            end
         end
         S_LOW: begin
            if (div_cnt == DIV_LAST) begin
               div_cnt_nx = '0;
               state_nx   = S_HIGH;
            end else begin
               div_cnt_nx = div_cnt + DIVW'(1);
            end
         end
         S_HIGH: begin
            if (div_cnt == DIV_LAST) begin
               div_cnt_nx = '0;
               if (bit_cnt == '0) begin
                  data_nx  = 1'b0;
                  busy_nx  = 1'b0;
                  state_nx = S_IDLE;
               end else begin
                  // The next bit goes out as ser_clk falls. It stays stable
                  // for the whole low phase and the high phase that follows.
                  shreg_nx   = shreg << 1;
                  data_nx    = shreg[WIDTH-2];
                  bit_cnt_nx = bit_cnt - CNTW'(1);
                  state_nx   = S_LOW;
               end
            end else begin
               div_cnt_nx = div_cnt + DIVW'(1);
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_fpga_debug_capture.sv
// Testbench for fpga_debug_capture (NCH=4, WIDTH=16, NDIG=4, CLKDIV=2).
// A behavioural model is stepped on every clock edge, and one compare process
// checks all DUT outputs against it #1 after each edge. Each serial dump is
// rebuilt from ser_clk rising edges and popped against an expected queue.
// Directed sections add hand-computed literal expectations.
module tb_fpga_debug_capture;

   localparam int NCH    = 4;
   localparam int SELW   = 2;
   localparam int W      = 16;
   localparam int NDIG   = 4;
   localparam int CLKDIV = 2;
   localparam int TOTAL  = 2*CLKDIV*W;

   // ------------------------------------------------------ clock and reset
   logic clk;
   logic reset;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [NCH-1:0]     strobe;
   logic [NCH*W-1:0]   data;
   logic [SELW-1:0]    sel;
   logic               freeze;
   logic               shift_start;
   logic [7*NDIG-1:0]  hex;
   logic               ser_clk, ser_data, ser_busy;
   logic [7:0]         evt_cnt;
   logic [NCH-1:0]     overrun;

   fpga_debug_capture #(
      .NCH(NCH), .SELW(SELW), .WIDTH(W), .NDIG(NDIG), .CLKDIV(CLKDIV)
   ) dut (
      .clk(clk), .reset(reset), .strobe(strobe), .data(data), .sel(sel),
      .freeze(freeze), .shift_start(shift_start), .hex(hex),
      .ser_clk(ser_clk), .ser_data(ser_data), .ser_busy(ser_busy),
      .evt_cnt(evt_cnt), .overrun(overrun)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------ the model
   logic [6:0] seg_tab [16];
   initial seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   function automatic logic [7*NDIG-1:0] model_hex(input logic [W-1:0] v, input int s);
      logic [7*NDIG-1:0] r;
      r = '0;
      for (int d = 0; d < NDIG; d++) begin
         if (s >= NCH || d*4 >= W) r[d*7 +: 7] = 7'h7F;
         else r[d*7 +: 7] = seg_tab[int'((v >> (4*d)) & 16'hF)];
      end
      return r;
   endfunction

   logic [W-1:0]      m_cap [NCH];
   int                m_evt [NCH];
   int                pend_at [NCH];   // clock-edge index at which the capture lands
   logic [NCH-1:0]    m_prev;
   logic [NCH-1:0]    m_ovr;
   logic [7*NDIG-1:0] m_hex;
   bit                m_valid = 0;
   bit                m_reset_edge = 0;
   bit                m_dump = 0;
   int                m_i = 0;
   logic [W-1:0]      m_snap;
   int                cyc = 0;
   logic [W-1:0]      exp_q [$];

   // A strobe first seen high at edge n is captured at edge n+2, with data and
   // freeze as seen at that edge. hex is one edge behind the stored value.
   always @(posedge clk) begin
      m_reset_edge = reset;
      if (reset) begin
         m_valid = 1;
         m_hex   = model_hex('0, int'(sel));
         for (int k = 0; k < NCH; k++) begin
            m_cap[k] = '0; m_evt[k] = 0; pend_at[k] = -1;
         end
         m_prev = '0; m_ovr = '0; m_dump = 0; m_i = 0;
         exp_q.delete();
      end else begin
         m_hex = model_hex(m_cap[sel], int'(sel));
         if (m_dump) begin
            m_i++;
            if (m_i == TOTAL) m_dump = 0;
         end else if (shift_start) begin
            m_dump = 1; m_i = 0; m_snap = m_cap[sel];
            exp_q.push_back(m_snap);
         end
         for (int k = 0; k < NCH; k++) begin
            if (pend_at[k] == cyc) begin
               pend_at[k] = -1;
               if (freeze) m_ovr[k] = 1'b1;
               else begin
                  m_cap[k] = data[k*W +: W];
                  if (m_evt[k] < 255) m_evt[k]++;
               end
            end
            if (strobe[k] && !m_prev[k]) pend_at[k] = cyc + 2;
            m_prev[k] = strobe[k];
         end
      end
      cyc++;
   end

   // ------------------------------------------------------- compare process
   logic [W-1:0] rx_word = '0;
   int           rx_n = 0;
   logic         rx_prev_clk = 1'b0, rx_prev_busy = 1'b0;

   always @(posedge clk) begin
      #1;
      if (m_valid) begin
         check("hex", 32'(hex), 32'(m_hex));
         check("evt_cnt", 32'(evt_cnt), 32'(m_evt[sel]));
         check("overrun", 32'(overrun), 32'(m_ovr));
         check("ser_busy", 32'(ser_busy), 32'(m_dump));
         check("ser_clk", 32'(ser_clk), (m_dump && (m_i % (2*CLKDIV)) >= CLKDIV) ? 1 : 0);
         check("ser_data", 32'(ser_data), m_dump ? 32'(m_snap[W-1 - m_i/(2*CLKDIV)]) : 0);
         if (m_reset_edge) begin
            rx_n = 0;
         end else begin
            if (ser_busy && !rx_prev_busy) begin rx_word = '0; rx_n = 0; end
            if (ser_clk && !rx_prev_clk) begin rx_word = {rx_word[W-2:0], ser_data}; rx_n++; end
            if (!ser_busy && rx_prev_busy) begin
               if (exp_q.size() == 0) check("dump_queue_empty", 1, 0);
               else begin
                  logic [W-1:0] e;
                  e = exp_q.pop_front();
                  check("dump_bits", rx_n, W);
                  check("dump_word", 32'(rx_word), 32'(e));
               end
            end
         end
         rx_prev_busy = ser_busy;
         rx_prev_clk  = ser_clk;
      end
   end

   // --------------------------------------------------------- driver tasks
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input int k, input logic [W-1:0] v, input int hi);
      @(negedge clk);
      data[k*W +: W] = v;
      strobe[k] = 1'b1;
      repeat (hi) @(negedge clk);
      strobe[k] = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // Starts a dump and samples it on falling edges until ser_busy drops.
   // disturb: ch1 capture and an extra shift_start mid-dump.
   // abort_at >= 0: assert reset for one edge at that sample.
   task automatic run_dump(input bit disturb, input int abort_at,
                           output logic [31:0] word, output int nb, output int busy_cnt);
      logic prev_clk;
      prev_clk = 1'b0; word = '0; nb = 0; busy_cnt = 0;
      @(negedge clk);
      shift_start = 1'b1;
      for (int j = 0; j < 200; j++) begin
         @(negedge clk);
         if (j == 0) shift_start = 1'b0;
         if (abort_at >= 0 && j == abort_at + 1) begin
            reset = 1'b0;
            break;
         end
         if (ser_busy) busy_cnt++;
         if (ser_clk && !prev_clk) begin word = {word[30:0], ser_data}; nb++; end
         prev_clk = ser_clk;
         if (disturb) begin
            if (j == 20) begin data[1*W +: W] = 16'h1234; strobe[1] = 1'b1; end
            if (j == 25) strobe[1] = 1'b0;
            if (j == 30) shift_start = 1'b1;
            if (j == 31) shift_start = 1'b0;
         end
         if (abort_at == j) reset = 1'b1;
         if (nb > 0 && !ser_busy && abort_at < 0) break;
      end
   endtask

   // ------------------------------------------------------------ stimulus
   int hold [NCH];

   initial begin
      logic [31:0] word;
      int nb, bc;
      reset = 1'b1; strobe = '0; data = '0; sel = '0; freeze = 1'b0; shift_start = 1'b0;
      for (int k = 0; k < NCH; k++) hold[k] = 0;
      idle(2);
      reset = 1'b0;
      check("reset_hex", 32'(hex), 32'({7'h40, 7'h40, 7'h40, 7'h40}));
      check("reset_evt", 32'(evt_cnt), 0);
      check("reset_ovr", 32'(overrun), 0);
      check("reset_busy", 32'(ser_busy), 0);

      // Single capture on channel 1.
      sel = 2'd1;
      pulse(1, 16'hBEEF, 4);
      idle(4);
      check("beef_hex", 32'(hex), 32'({7'h03, 7'h06, 7'h06, 7'h0E}));
      check("beef_evt", 32'(evt_cnt), 1);

      // Simultaneous edges, then a frozen capture.
      @(negedge clk);
      data[0*W +: W] = 16'h1234; data[2*W +: W] = 16'h00A5;
      strobe[0] = 1'b1; strobe[2] = 1'b1;
      idle(4);
      strobe = '0;
      idle(4);
      sel = 2'd0; idle(2);
      check("sim_hex0", 32'(hex), 32'({7'h79, 7'h24, 7'h30, 7'h19}));
      sel = 2'd2; idle(2);
      check("sim_hex2", 32'(hex), 32'({7'h40, 7'h40, 7'h08, 7'h12}));
      freeze = 1'b1;
      pulse(2, 16'hFFFF, 4);
      idle(4);
      freeze = 1'b0;
      idle(2);
      check("frz_hex2", 32'(hex), 32'({7'h40, 7'h40, 7'h08, 7'h12}));
      check("frz_evt2", 32'(evt_cnt), 1);
      check("frz_ovr", 32'(overrun), 32'(4'b0100));

      // A long-held strobe counts once.
      sel = 2'd0;
      @(negedge clk);
      data[0*W +: W] = 16'h5555; strobe[0] = 1'b1;
      idle(20);
      strobe[0] = 1'b0;
      idle(4);
      check("hold_evt0", 32'(evt_cnt), 2);
      check("hold_hex0", 32'(hex), 32'({7'h12, 7'h12, 7'h12, 7'h12}));

      // Saturation.
      sel = 2'd3;
      repeat (300) pulse(3, 16'($urandom), 3);
      idle(4);
      check("sat_evt3", 32'(evt_cnt), 255);

      // Serial dump of BEEF, disturbed mid-dump.
      sel = 2'd1;
      run_dump(1'b1, -1, word, nb, bc);
      check("dump_beef", word, 32'hBEEF);
      check("dump_beef_n", nb, 16);
      check("dump_beef_busy", bc, TOTAL);
      idle(3);

      // Reset at bit 7, then a dump of the cleared channel.
      run_dump(1'b0, 7*2*CLKDIV + 1, word, nb, bc);
      check("abort_busy", 32'(ser_busy), 0);
      check("abort_clk", 32'(ser_clk), 0);
      check("abort_data", 32'(ser_data), 0);
      idle(2);
      run_dump(1'b0, -1, word, nb, bc);
      check("dump_zero", word, 0);
      check("dump_zero_n", nb, 16);
      check("dump_zero_busy", bc, TOTAL);
      idle(3);

      // Randomised traffic; no new pulses start near the end.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         shift_start = ($urandom_range(0, 30) == 0);
         if ($urandom_range(0, 15) == 0) sel = SELW'($urandom_range(0, NCH-1));
         if ($urandom_range(0, 40) == 0) freeze = ~freeze;
         for (int k = 0; k < NCH; k++) begin
            if (hold[k] > 0) hold[k]--;
            else if (strobe[k]) begin strobe[k] = 1'b0; hold[k] = $urandom_range(1, 4); end
            else if (c < 2900 && $urandom_range(0, 9) == 0) begin
               data[k*W +: W] = 16'($urandom);
               strobe[k] = 1'b1;
               hold[k] = $urandom_range(2, 5);
            end
         end
      end
      shift_start = 1'b0; freeze = 1'b0; strobe = '0;
      idle(2*TOTAL);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule

// File: doc/fpga_debug_capture.md
Name: fpga_debug_capture

Overview:
- Parametrised debug-capture and display block for the FPGA test harness around the RFID tag top level.
- Latches up to NCH tag-internal values (packet type, read/write bank, pointer, slot counter, ...) on their completion strobes. These strobes are synchronised into the system clock; they are not used as clocks.
- Drives NDIG seven-segment digits with the selected channel and serially dumps that channel on two GPIO debug pins.
- Replaces ad-hoc per-signal latch and display logic in board wrappers.

Parameters:
NCH, 4, number of capture channels (1..16)
SELW, 2, width of channel select; 2**SELW >= NCH
WIDTH, 16, bits per channel (4..32)
NDIG, 4, seven-segment digits driven (1..8)
CLKDIV, 8, system clocks per ser_clk phase (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
strobe  in  NCH  per-channel capture event; asynchronous to clk, level held >=3 clk
data  in  NCH*WIDTH  channel k value at bits [k*WIDTH +: WIDTH]; stable while strobe[k] high
sel  in  SELW  channel shown on hex, ser_*, evt_cnt
freeze  in  1  high = ignore all captures
shift_start  in  1  single-cycle pulse: begin serial dump of selected channel
hex  out  7*NDIG  digit d at [d*7 +: 7], active-low segments, bit0=a .. bit6=g
ser_clk  out  1  serial dump clock
ser_data  out  1  serial dump data, MSB first
ser_busy  out  1  high while dump in progress
evt_cnt  out  8  accepted-capture count of selected channel
overrun  out  NCH  sticky: strobe edge arrived while frozen

Behaviour:
- Reset (clk edge with reset=1): all capture registers 0, all counters 0, overrun 0, ser_clk 0, ser_data 0, ser_busy 0, serial FSM to IDLE.
  - hex shows all digits as "0" (7'h40) from the cycle after reset, except blanked digits.
  - Reset has priority over every other event, including a dump in progress.
- Synchronisation: each strobe[k] passes through a 2-flop synchroniser plus an edge-detect flop.
  - Rising edge detected (edge[k]) on the 3rd clk edge after strobe[k] is first sampled high.
  - In that cycle: if freeze=0, cap[k] <= data[k] and evt[k] increments, saturating at 255. If freeze=1, cap[k] and evt[k] are held and overrun[k] <= 1.
  - Channels are independent: simultaneous edges on several channels all capture in the same cycle.
  - A strobe held high yields exactly one capture.
  - Falling edges are ignored.
- Display: hex is registered and updates 1 cycle after any change of cap[sel] or sel.
  - Digit d shows nibble d of cap[sel] (d=0 is the LSB nibble).
  - Digits with d*4 >= WIDTH are blanked (7'h7F). Nibbles above NDIG*4 are not displayed.
  - Encoding 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
  - If sel >= NCH, all digits are blanked and evt_cnt = 0.
- evt_cnt = evt[sel], combinational from registered counters.
- Serial FSM states: IDLE, LOW, HIGH.
  - IDLE: ser_busy=0, ser_clk=0. On shift_start=1:
    - snapshot shreg <= cap[sel] (0 if sel >= NCH);
    - bit counter <= WIDTH-1;
    - ser_data <= MSB;
    - ser_busy <= 1;
    - enter LOW.
  - LOW: ser_clk=0 for CLKDIV cycles, then enter HIGH.
  - HIGH: ser_clk=1 for CLKDIV cycles, then:
    - if bit counter = 0: enter IDLE, ser_data <= 0, ser_busy <= 0;
    - else: shift shreg left, ser_data <= next bit, decrement counter, enter LOW.
  - Total dump length: 2*CLKDIV*WIDTH cycles from the first cycle ser_busy=1. Receiver samples on ser_clk rising edge.
  - shift_start while ser_busy=1 is ignored.
  - Captures during a dump update cap but do not affect the dump, which uses the snapshot.
  - Changing sel mid-dump affects hex and evt_cnt only.
- freeze does not pause the dump.
- overrun is cleared only by reset.

Test Plan:
- Reset: assert reset 2 cycles, NCH=4, WIDTH=16 -> hex = {40,40,40,40}, evt_cnt=0, overrun=0, ser_busy=0.
- Capture: data[1]=16'hBEEF, pulse strobe[1] 4 clk, sel=1 -> cap updates 3 clk after strobe sampled; hex d3..d0 = 03,06,06,0E one cycle later; evt_cnt=1.
- Simultaneous and freeze: strobe[0] and strobe[2] rise together with data 16'h1234 / 16'h00A5 -> both captured the same cycle. Set freeze=1, strobe[2] again with 16'hFFFF -> cap[2] stays 00A5, evt[2]=1, overrun=4'b0100.
- Saturation: 300 strobe pulses on ch3 -> evt_cnt=255 with sel=3.
- Serial dump: CLKDIV=2, cap[1]=BEEF, sel=1, shift_start pulse -> 16 ser_clk periods of 4 clk each; bits 1011111011101111 MSB first on rising edges; ser_busy high exactly 64 cycles. A second shift_start mid-dump is ignored. A ch1 capture mid-dump does not alter the bitstream.
- Reset mid-dump: reset at bit 7 -> next cycle ser_busy=0, ser_clk=0, ser_data=0. A shift_start after reset dumps 0x0000.
